// File: rtl/gcd_ctrl_pkg.sv
// Shared constants for the subtract-based GCD controller: state encodings and
// operand mux selects.
package gcd_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_CMP   = 3'd2;
  localparam state_t S_SUB_A = 3'd3;
  localparam state_t S_SUB_B = 3'd4;
  localparam state_t S_DONE  = 3'd5;
  localparam state_t S_ERR   = 3'd6;

  localparam logic SEL_IN   = 1'b0;
  localparam logic SEL_DIFF = 1'b1;

endpackage

// File: rtl/gcd_ctrl_if.sv
// Controller <-> datapath/button-logic signal bundle. master = controller side,
// slave = datapath and start-request side.
interface gcd_ctrl_if #(
  parameter int CNT_W = 4
);

  logic             start;
  logic             a_eq_b;
  logic             a_gt_b;
  logic             a_zero;
  logic             b_zero;
  logic             ld_a;
  logic             ld_b;
  logic             sel_a;
  logic             sel_b;
  logic             clr_ab;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_count;

  modport master (
    input  start, a_eq_b, a_gt_b, a_zero, b_zero,
    output ld_a, ld_b, sel_a, sel_b, clr_ab, busy, done, err, iter_count
  );

  modport slave (
    output start, a_eq_b, a_gt_b, a_zero, b_zero,
    input  ld_a, ld_b, sel_a, sel_b, clr_ab, busy, done, err, iter_count
  );

endinterface

// File: rtl/gcd_iter_cnt.sv
// Subtraction counter for the GCD controller: sync clear, increment, and a
// terminal flag when the count reaches MAX_ITER.
module gcd_iter_cnt #(
  parameter int MAX_ITER = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // The controller checks term before it ever increments, so count cannot wrap.
  assign term = (count == CNT_W'(MAX_ITER));

endmodule

// File: rtl/gcd_ctrl.sv
// Moore FSM sequencing the subtract-based GCD datapath.
// Optional macro GCD_CTRL_DONE_PULSE_EN: DONE/ERR last one cycle instead of
// holding until start drops.
module gcd_ctrl
  import gcd_ctrl_pkg::*;
#(
  parameter int MAX_ITER = 15,
  parameter int CNT_W    = 4
) (
  input logic        clk,
  input logic        reset,
  gcd_ctrl_if.master bus
);

  state_t           state;
  state_t           state_nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_term;
  logic [CNT_W-1:0] count;

  logic ld_a, ld_b, sel_a, sel_b, clr_ab, busy, done, err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_CMP;
      S_CMP: begin
        if (bus.a_zero || bus.b_zero) state_nxt = S_ERR;
        else if (bus.a_eq_b)          state_nxt = S_DONE;
        else if (cnt_term)            state_nxt = S_ERR;
        else if (bus.a_gt_b)          state_nxt = S_SUB_A;
        else                          state_nxt = S_SUB_B;
      end
      S_SUB_A: state_nxt = S_CMP;
      S_SUB_B: state_nxt = S_CMP;
`ifdef GCD_CTRL_DONE_PULSE_EN
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
`else
      S_DONE:  if (!bus.start) state_nxt = S_IDLE;
      S_ERR:   if (!bus.start) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cnt_clr = (state == S_LOAD);
  assign cnt_inc = (state == S_SUB_A) || (state == S_SUB_B);

  gcd_iter_cnt #(
    .MAX_ITER (MAX_ITER),
    .CNT_W    (CNT_W)
  ) u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count),
    .term  (cnt_term)
  );

  always_comb begin
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    sel_a  = SEL_IN;
    sel_b  = SEL_IN;
    clr_ab = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      S_LOAD: begin
        ld_a = 1'b1;
        ld_b = 1'b1;
        busy = 1'b1;
      end
      S_CMP:   busy = 1'b1;
      S_SUB_A: begin
        ld_a  = 1'b1;
        sel_a = SEL_DIFF;
        busy  = 1'b1;
      end
      S_SUB_B: begin
        ld_b  = 1'b1;
        sel_b = SEL_DIFF;
        busy  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR: begin
        err    = 1'b1;
        clr_ab = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ld_a       = ld_a;
  assign bus.ld_b       = ld_b;
  assign bus.sel_a      = sel_a;
  assign bus.sel_b      = sel_b;
  assign bus.clr_ab     = clr_ab;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.iter_count = count;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl: two controllers (MAX_ITER 15 and 3), each
// with a falling-edge datapath model, checked against an arithmetic GCD model.
module tb_gcd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ext_a = '0;
  logic [3:0] ext_b = '0;

  int checks = 0;
  int failures = 0;

  int maxv [2] = '{15, 3};

  always #5 clk = ~clk;

  gcd_ctrl_if #(.CNT_W(4)) bus0 ();
  gcd_ctrl_if #(.CNT_W(4)) bus1 ();

  gcd_ctrl #(.MAX_ITER(15), .CNT_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.master)
  );

  gcd_ctrl #(.MAX_ITER(3), .CNT_W(4)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  logic [3:0] areg [2] = '{4'd0, 4'd0};
  logic [3:0] breg [2] = '{4'd0, 4'd0};

  wire [1:0] lda_w  = {bus1.ld_a,   bus0.ld_a};
  wire [1:0] ldb_w  = {bus1.ld_b,   bus0.ld_b};
  wire [1:0] sela_w = {bus1.sel_a,  bus0.sel_a};
  wire [1:0] selb_w = {bus1.sel_b,  bus0.sel_b};
  wire [1:0] clr_w  = {bus1.clr_ab, bus0.clr_ab};
  wire [1:0] busy_w = {bus1.busy,   bus0.busy};
  wire [1:0] done_w = {bus1.done,   bus0.done};
  wire [1:0] err_w  = {bus1.err,    bus0.err};
  logic [3:0] iter_w [2];
  assign iter_w[0] = bus0.iter_count;
  assign iter_w[1] = bus1.iter_count;

  wire [11:0] outs0 = {bus0.ld_a, bus0.ld_b, bus0.sel_a, bus0.sel_b, bus0.clr_ab,
                       bus0.busy, bus0.done, bus0.err, bus0.iter_count};
  wire [11:0] outs1 = {bus1.ld_a, bus1.ld_b, bus1.sel_a, bus1.sel_b, bus1.clr_ab,
                       bus1.busy, bus1.done, bus1.err, bus1.iter_count};

  assign bus0.start  = start;
  assign bus1.start  = start;
  assign bus0.a_eq_b = (areg[0] == breg[0]);
  assign bus0.a_gt_b = (areg[0] >  breg[0]);
  assign bus0.a_zero = (areg[0] == 4'd0);
  assign bus0.b_zero = (breg[0] == 4'd0);
  assign bus1.a_eq_b = (areg[1] == breg[1]);
  assign bus1.a_gt_b = (areg[1] >  breg[1]);
  assign bus1.a_zero = (areg[1] == 4'd0);
  assign bus1.b_zero = (breg[1] == 4'd0);

  // Operand registers capture on the falling edge, half a cycle after the controller.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr_w[i]) begin
        areg[i] <= 4'd0;
        breg[i] <= 4'd0;
      end else begin
        if (lda_w[i]) areg[i] <= sela_w[i] ? areg[i] - breg[i] : ext_a;
        if (ldb_w[i]) breg[i] <= selb_w[i] ? breg[i] - areg[i] : ext_b;
      end
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Expected outcome from GCD arithmetic: zero operand is an error, otherwise
  // the run times out only if it needs more subtractions than maxi.
  function automatic void refModel(input int a, input int b, input int maxi,
                                   output int exp_err, output int exp_n,
                                   output int exp_g, output int exp_lat);
    int x, y, n, p, q, t;
    exp_g = 0;
    if (a == 0 || b == 0) begin
      exp_err = 1;
      exp_n   = 0;
      exp_lat = 3;
      return;
    end
    x = a; y = b; n = 0;
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
      n++;
    end
    p = a; q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    exp_g   = p;
    exp_err = (n > maxi) ? 1 : 0;
    exp_n   = (n > maxi) ? maxi : n;
    exp_lat = 3 + 2 * exp_n;
  endfunction

  task automatic waitIdle(input string tag);
    int ok;
    ok = 0;
    for (int c = 0; c < 60 && ok == 0; c++) begin
      @(posedge clk); #1;
      if (busy_w == 2'b00 && done_w == 2'b00 && err_w == 2'b00) ok = 1;
    end
    checkOutput({tag, "_idle"}, ok, 1);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    int fin [2];
    int ldcnt [2];
    int busycnt [2];
    int overlap [2];
    int f_done [2];
    int f_err [2];
    int f_clr [2];
    int f_iter [2];
    int f_res [2];
    int e_err, e_n, e_g, e_lat;
    string tag;
    for (int i = 0; i < 2; i++) begin
      fin[i] = 0; ldcnt[i] = 0; busycnt[i] = 0; overlap[i] = 0;
      f_done[i] = 0; f_err[i] = 0; f_clr[i] = 0; f_iter[i] = 0; f_res[i] = 0;
    end
    ext_a = a;
    ext_b = b;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 1; k <= 45 && (fin[0] == 0 || fin[1] == 0); k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (fin[i] == 0) begin
          ldcnt[i] += int'(lda_w[i]) + int'(ldb_w[i]);
          if (busy_w[i]) busycnt[i]++;
          if (clr_w[i] && (lda_w[i] || ldb_w[i])) overlap[i]++;
          if (done_w[i] || err_w[i]) begin
            fin[i]    = k;
            f_done[i] = int'(done_w[i]);
            f_err[i]  = int'(err_w[i]);
            f_clr[i]  = int'(clr_w[i]);
            f_iter[i] = int'(iter_w[i]);
            f_res[i]  = int'(areg[i]);
          end
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      refModel(int'(a), int'(b), maxv[i], e_err, e_n, e_g, e_lat);
      tag = $sformatf("gcd(%0d,%0d)m%0d", a, b, maxv[i]);
      checkOutput({tag, "_lat"},   fin[i],     e_lat);
      checkOutput({tag, "_done"},  f_done[i],  1 - e_err);
      checkOutput({tag, "_err"},   f_err[i],   e_err);
      checkOutput({tag, "_clr"},   f_clr[i],   e_err);
      checkOutput({tag, "_iter"},  f_iter[i],  e_n);
      checkOutput({tag, "_ldcnt"}, ldcnt[i],   2 + e_n);
      checkOutput({tag, "_busy"},  busycnt[i], e_lat - 1);
      checkOutput({tag, "_clrld"}, overlap[i], 0);
      if (e_err == 0) checkOutput({tag, "_res"}, f_res[i], e_g);
    end
    waitIdle(tag);
  endtask

  task automatic holdTest();
    int k;
    ext_a = 4'd5;
    ext_b = 4'd5;
    @(posedge clk); #1;
    start = 1'b1;
    k = 0;
    for (int c = 1; c <= 10 && k == 0; c++) begin
      @(posedge clk); #1;
      if (done_w[0]) k = c;
    end
    checkOutput("hold_lat", k, 3);
`ifndef GCD_CTRL_DONE_PULSE_EN
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("hold_done", int'(done_w[0]), 1);
      checkOutput("hold_nobusy", int'(busy_w[0]), 0);
    end
`else
    @(posedge clk); #1;
    checkOutput("pulse_done_low", int'(done_w[0]), 0);
    checkOutput("pulse_idle", int'(busy_w[0]), 0);
    @(posedge clk); #1;
    checkOutput("pulse_reload", int'(lda_w[0] && ldb_w[0] && busy_w[0]), 1);
`endif
    start = 1'b0;
    waitIdle("hold");
  endtask

  task automatic resetTest();
    ext_a = 4'd6;
    ext_b = 4'd4;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_in_subb", int'(ldb_w[0] && selb_w[0] && busy_w[0]), 1);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_outs0", int'(outs0), 0);
    checkOutput("rst_outs1", int'(outs1), 0);
    reset = 1'b1;
    applyStimulus(4'd6, 4'd4);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] ra, rb;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outs0", int'(outs0), 0);
    checkOutput("reset_outs1", int'(outs1), 0);
    reset = 1'b1;

    applyStimulus(4'd6, 4'd4);
    applyStimulus(4'd5, 4'd5);
    applyStimulus(4'd0, 4'd7);
    applyStimulus(4'd15, 4'd1);
    applyStimulus(4'd7, 4'd0);
    applyStimulus(4'd0, 4'd0);
    applyStimulus(4'd1, 4'd15);
    holdTest();
    resetTest();

    for (int r = 0; r < 25; r++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      applyStimulus(ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
